// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op encodings, FSM states and iteration count for mult_div_unit
package mult_div_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int ITER_CNT = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mult_div_step.sv
// mult_div_step: one combinational Booth (mult) or restoring-divide iteration
// Ports: i_is_div selects divide; i_acc/i_q/i_qm1 current {Acc,Q,Q_-1};
// i_m multiplicand or divisor magnitude; o_acc/o_q/o_qm1 next iteration state.
module mult_div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rsh;
    logic [WIDTH:0] w_diff;
    logic           w_ge;
    always_comb begin
        w_sum  = ({i_q[0], i_qm1} == 2'b01) ? i_acc + i_m :
                 ({i_q[0], i_qm1} == 2'b10) ? i_acc - i_m : i_acc;
        // Partial remainder stays below the divisor (<= 2^31), so bit WIDTH of the difference is its sign.
        w_rsh  = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
        w_diff = w_rsh - i_m;
        w_ge   = !w_diff[WIDTH];
        o_acc  = i_is_div ? (w_ge ? w_diff : w_rsh) : {w_sum[WIDTH], w_sum[WIDTH:1]};
        o_q    = i_is_div ? {i_q[WIDTH-2:0], w_ge} : {w_sum[0], i_q[WIDTH-1:1]};
        o_qm1  = i_is_div ? i_qm1 : i_q[0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit Booth multiply / restoring divide feeding HI/LO
// Ports: clk; reset (sync, active-low); start; op[0] div, op[1] unsigned;
// a_in/b_in operands; busy; done (HI/LO write); div_zero; hi_out/lo_out.
// Optional: MULT_DIV_UNSIGNED_EN enables MULTU/DIVU via op[1].
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    state_t               r_state;
    state_t               w_state_n;
    logic [COUNT_W-1:0]   r_cnt;
    logic [WIDTH:0]       r_acc;
    logic [WIDTH-1:0]     r_q;
    logic                 r_qm1;
    logic [WIDTH:0]       r_m;
    logic                 r_is_div;
    logic                 r_dz;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_fix;
    logic [WIDTH:0]       w_acc_n;
    logic [WIDTH-1:0]     w_q_n;
    logic                 w_qm1_n;
    logic                 w_uns;
    logic                 w_go;
    logic                 w_dz_in;
    logic                 w_last;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_lo;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_q      (r_q),
        .i_qm1    (r_qm1),
        .i_m      (r_m),
        .o_acc    (w_acc_n),
        .o_q      (w_q_n),
        .o_qm1    (w_qm1_n)
    );

    always_comb begin
`ifdef MULT_DIV_UNSIGNED_EN
        w_uns = op[1];
`else
        w_uns = op[1] & 1'b0;
`endif
        w_go      = start && (r_state != RUN);
        w_dz_in   = op[0] && (b_in == '0);
        w_last    = (r_state == RUN) && (r_cnt == COUNT_W'(ITER_CNT - 1));
        w_state_n = w_go ? (w_dz_in ? DONE : RUN) : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
        w_a_neg   = !w_uns && a_in[WIDTH-1];
        w_b_neg   = !w_uns && b_in[WIDTH-1];
        w_a_mag   = w_a_neg ? -a_in : a_in;
        w_b_mag   = w_b_neg ? -b_in : b_in;
        // Booth treats the multiplier as signed; an unsigned multiplier with its MSB set needs M added into HI.
        w_hi      = r_is_div ? (r_neg_r ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0])
                             : w_acc_n[WIDTH-1:0] + (r_fix ? r_m[WIDTH-1:0] : '0);
        w_lo      = (r_is_div && r_neg_q) ? -w_q_n : w_q_n;
        busy      = (r_state == RUN);
        done      = (r_state == DONE);
        div_zero  = (r_state == DONE) && r_dz;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fix    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else if (w_go) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= op[0] ? w_a_mag : b_in;
            r_qm1    <= 1'b0;
            r_m      <= op[0] ? {1'b0, w_b_mag} : {w_a_neg, a_in};
            r_is_div <= op[0];
            r_dz     <= w_dz_in;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_fix    <= w_uns && b_in[WIDTH-1];
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_n;
            r_q   <= w_q_n;
            r_qm1 <= w_qm1_n;
            if (w_last) begin
                hi_out <= w_hi;
                lo_out <= w_lo;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors
module tb_mult_div_unit;
    import mult_div_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_hi"}, hi_out, e.hi);
                chk({e.nm, "_lo"}, lo_out, e.lo);
                chk({e.nm, "_div_zero"}, 32'(div_zero), 32'(e.dz));
                chk({e.nm, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({e.nm, "_busy_with_done"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int lat, input string nm);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        op = o;
        a_in = a;
        b_in = b;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.cyc = cyc + lat;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        reset = 1'b1;
        idle(2);

        issue(OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mult_7_m3");
        chk("busy_cycle1", 32'(busy), 32'd1);
        idle(31);
        chk("busy_cycle32", 32'(busy), 32'd1);
        chk("lo_held_in_run", lo_out, 32'd0);
        idle(1);
        chk("busy_cycle33", 32'(busy), 32'd0);
        idle(3);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, "div_m7_2");
        idle(35);
        issue(OP_DIV, 32'd5, 32'd2, 32'd1, 32'd2, 1'b0, 33, "div_5_2");
        idle(35);
        issue(OP_DIV, 32'd5, 32'd0, 32'd1, 32'd2, 1'b1, 1, "div_by_zero");
        idle(3);

        issue(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, "mult_min_min");
        idle(9);
        start = 1'b1;
        op = OP_DIV;
        a_in = 32'd9;
        b_in = 32'd0;
        idle(1);
        start = 1'b0;
        idle(26);

        issue(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, "mult_3_5");
        idle(31);
        issue(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 33, "div_b2b_100_m7");
        idle(35);

`ifdef MULT_DIV_UNSIGNED_EN
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, "multu_ff_2");
`else
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, "multu_ff_2");
`endif
        idle(35);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, "div_min_m1");
        idle(35);

        issue(OP_MULT, 32'd11, 32'd13, 32'd0, 32'd143, 1'b0, 33, "mult_abort");
        idle(11);
        reset = 1'b0;
        sb.delete();
        idle(1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        reset = 1'b1;
        idle(40);

        chk("pending_expectations", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
